// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; shares the go/done handshake of the multiplier.
module div_iter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [5:0] PH_LOAD = 6'd0;
  localparam logic [5:0] PH_FIX  = 6'd33;

  logic [5:0]  phase_q, phase_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        dz_q, dz_d;
  logic [31:0] q_q, q_d;
  logic [31:0] d_q, d_d;
  logic [31:0] r_q, r_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;

  logic [32:0] t;
  logic        fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    phase_d = phase_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    a_mag = (sign & dividend[31]) ? -dividend : dividend;
    b_mag = (sign & divisor[31])  ? -divisor  : divisor;
    // Trial subtract; bit 32 set means the shifted remainder was smaller.
    t = {r_q, q_q[31]} - {1'b0, d_q};

    fix     = go && (phase_q == PH_FIX);
    quo_fix = dz_q ? 32'hFFFF_FFFF : (negq_q ? -q_q : q_q);
    rem_fix = dz_q ? dvd_q : (negr_q ? -r_q : r_q);

    if (!go) begin
      phase_d = PH_LOAD;
    end else if (phase_q == PH_LOAD) begin
      negq_d  = sign & (dividend[31] ^ divisor[31]);
      negr_d  = sign & dividend[31];
      dz_d    = (divisor == 32'd0);
      q_d     = a_mag;
      d_d     = b_mag;
      r_d     = 32'd0;
      dvd_d   = dividend;
      phase_d = phase_q + 6'd1;
    end else if (phase_q == PH_FIX) begin
      quo_d   = quo_fix;
      rem_d   = rem_fix;
      phase_d = PH_LOAD;
    end else begin
      if (!t[32]) begin
        r_d = t[31:0];
        q_d = {q_q[30:0], 1'b1};
      end else begin
        r_d = {r_q[30:0], q_q[31]};
        q_d = {q_q[30:0], 1'b0};
      end
      phase_d = phase_q + 6'd1;
    end

    done      = reset_n & fix;
    quotient  = done ? quo_fix : quo_q;
    remainder = done ? rem_fix : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q <= PH_LOAD;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= 32'd0;
      d_q     <= 32'd0;
      r_q     <= 32'd0;
      dvd_q   <= 32'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
    end else begin
      phase_q <= phase_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter against an arithmetic reference.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  div_iter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (go),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    logic [63:0] qq, rr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      qq = 64'(sa / sb);
      rr = 64'(sa % sb);
      q = qq[31:0];
      r = rr[31:0];
    end
  endtask

  // Holds go until done (bounded), drops it on the next cycle.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int dcyc, output int ndone,
                        output logic [31:0] q, output logic [31:0] r);
    @(negedge clk);
    sign = s; dividend = a; divisor = b; go = 1'b1;
    dcyc = -1; ndone = 0; q = 'x; r = 'x;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (done) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = c; q = quotient; r = remainder;
        end
      end
      @(negedge clk);
      if (dcyc > 0) go = 1'b0;
    end
    go = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; go = 1'b1; sign = 1'b0;
    dividend = 32'd100; divisor = 32'd7;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL reset_done: got %b want 0", done);
    end
    total++;
    if (quotient !== 32'd0 || remainder !== 32'd0) begin
      bad++; $display("FAIL reset_out: got q=%h r=%h want 0/0", quotient, remainder);
    end
    go = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic        s[7];
    logic [31:0] a[7], b[7];
    logic [31:0] eq, er, q, r;
    int dc, nd;
    s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    a = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFB, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    b = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};
    for (int i = 0; i < 7; i++) begin
      ref_div(s[i], a[i], b[i], eq, er);
      run_op(s[i], a[i], b[i], dc, nd, q, r);
      total++;
      if (dc !== 34 || nd !== 1) begin
        bad++; $display("FAIL dir%0d_latency: got cyc=%0d n=%0d want 34/1", i, dc, nd);
      end
      total++;
      if (q !== eq || r !== er) begin
        bad++; $display("FAIL dir%0d_result: got q=%h r=%h want q=%h r=%h", i, q, r, eq, er);
      end
      total++;
      if (quotient !== eq || remainder !== er) begin
        bad++; $display("FAIL dir%0d_hold: got q=%h r=%h want q=%h r=%h",
                        i, quotient, remainder, eq, er);
      end
    end
    total++;
    if (quotient !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL unsigned_max: got %h want ffffffff", quotient);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, eq, er, q, r;
    logic s;
    int dc, nd;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = b >> $urandom_range(16, 31);
        1: b = 32'($urandom_range(0, 3)) - 32'd1;
        2: a = 32'h8000_0000;
        default: ;
      endcase
      ref_div(s, a, b, eq, er);
      run_op(s, a, b, dc, nd, q, r);
      total++;
      if (dc !== 34 || nd !== 1 || q !== eq || r !== er) begin
        bad++;
        $display("FAIL rnd%0d s=%b a=%h b=%h: got cyc=%0d n=%0d q=%h r=%h want 34/1 q=%h r=%h",
                 i, s, a, b, dc, nd, q, r, eq, er);
      end
    end
  endtask

  task automatic test_abort;
    logic [31:0] pq, pr, q, r;
    int dc, nd, early;
    pq = quotient; pr = remainder;
    early = 0;
    @(negedge clk);
    sign = 1'b0; dividend = 32'd1000; divisor = 32'd3; go = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      #1; if (done) early++;
      @(negedge clk);
    end
    go = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1; if (done) early++;
      @(negedge clk);
    end
    total++;
    if (early !== 0 || quotient !== pq || remainder !== pr) begin
      bad++; $display("FAIL abort_quiet: got n=%0d q=%h r=%h want 0 q=%h r=%h",
                      early, quotient, remainder, pq, pr);
    end
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, dc, nd, q, r);
    total++;
    if (dc !== 34 || nd !== 1 || q !== 32'h0FFF_FFFF || r !== 32'hF) begin
      bad++; $display("FAIL abort_resume: got cyc=%0d n=%0d q=%h r=%h want 34/1 0fffffff/f",
                      dc, nd, q, r);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] eq1, er1, eq2, er2;
    int d1, d2, nd;
    logic [31:0] q1, r1, q2, r2;
    ref_div(1'b1, 32'hFFFF_FF00, 32'd9, eq1, er1);
    ref_div(1'b0, 32'hDEAD_BEEF, 32'd1234, eq2, er2);
    d1 = -1; d2 = -1; nd = 0;
    q1 = 'x; r1 = 'x; q2 = 'x; r2 = 'x;
    @(negedge clk);
    sign = 1'b1; dividend = 32'hFFFF_FF00; divisor = 32'd9; go = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      #1;
      if (done) begin
        nd++;
        if (d1 < 0) begin d1 = c; q1 = quotient; r1 = remainder; end
        else if (d2 < 0) begin d2 = c; q2 = quotient; r2 = remainder; end
      end
      @(negedge clk);
      if (c == 34) begin
        sign = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd1234;
      end
      if (c == 68) go = 1'b0;
    end
    go = 1'b0;
    total++;
    if (d1 !== 34 || d2 !== 68 || nd !== 2) begin
      bad++; $display("FAIL b2b_timing: got %0d,%0d n=%0d want 34,68 n=2", d1, d2, nd);
    end
    total++;
    if (q1 !== eq1 || r1 !== er1 || q2 !== eq2 || r2 !== er2) begin
      bad++; $display("FAIL b2b_result: got %h/%h %h/%h want %h/%h %h/%h",
                      q1, r1, q2, r2, eq1, er1, eq2, er2);
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    nd = 0;
    total++;
    if (quotient === 32'd0 && remainder === 32'd0) begin
      bad++; $display("FAIL rstmid_pre: got q=%h r=%h want nonzero", quotient, remainder);
    end
    @(negedge clk);
    sign = 1'b0; dividend = 32'd77; divisor = 32'd5; go = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      #1; if (done) nd++;
      @(negedge clk);
      if (c == 20) reset_n = 1'b0;
      if (c == 22) reset_n = 1'b1;
    end
    go = 1'b0;
    total++;
    if (nd !== 0) begin
      bad++; $display("FAIL rstmid_done: got n=%0d want 0", nd);
    end
    #1;
    total++;
    if (quotient !== 32'd0 || remainder !== 32'd0) begin
      bad++; $display("FAIL rstmid_out: got q=%h r=%h want 0/0", quotient, remainder);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative 32-bit integer divider for the execute stage's M-extension path: DIV, DIVU, REM and REMU.
- Companion to the Booth multiplier, with the same go/done interface so the execute stage sequences both units identically.
- Uses a restoring algorithm on operand magnitudes with sign fixup.
- Fixed latency: one quotient bit per cycle.

Parameters:
- none: width is fixed at 32.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- go  in  1  request; held high by the requester until done is seen
- sign  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
- dividend  in  32  numerator; must be stable while go is high
- divisor  in  32  denominator; must be stable while go is high
- done  out  1  high for exactly one cycle when results are valid
- quotient  out  32  quotient result
- remainder  out  32  remainder result

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, port reset_n.
- Reset (reset_n low at a posedge):
  - phase counter returns to LOAD.
  - quotient and remainder registers clear to 0.
  - done is 0 whenever reset_n is low.
- Phase counter runs 0..33 and advances only while go is high.
- go low in any cycle aborts the operation:
  - counter returns to LOAD (phase 0).
  - no done is produced.
  - output registers hold their last values.
- Phase 0 (LOAD, first cycle go is high):
  - latch neg_q = sign & (dividend[31] ^ divisor[31]).
  - latch neg_r = sign & dividend[31].
  - latch div_zero = (divisor == 0).
  - latch |dividend| into quotient shift register Q[31:0] (magnitude only when sign = 1, else raw).
  - latch |divisor| into D[31:0].
  - clear partial remainder R[32:0].
  - magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- Phases 1..32 (ITER), one bit per cycle:
  - T = {R[31:0], Q[31]} - {1'b0, D}, computed at 33 bits.
  - if T[32] == 0: R <= T, Q <= {Q[30:0], 1}.
  - else: R <= {R[31:0], Q[31]}, Q <= {Q[30:0], 0}.
- Phase 33 (FIX):
  - div_zero set: quotient <= 0xFFFFFFFF, remainder <= latched dividend (raw, unsigned and signed alike).
  - otherwise: quotient <= neg_q ? -Q : Q; remainder <= neg_r ? -R[31:0] : R[31:0].
  - signed overflow (0x80000000 / -1) falls out naturally as quotient 0x80000000, remainder 0; no special case is needed.
  - done = go & (phase == 33), combinational from the phase register.
  - result values are presented combinationally in this cycle and registered at the edge that ends it.
  - quotient and remainder stay stable after done until the next FIX phase or reset.
- Latency: done is high in the 34th consecutive cycle of go held high.
- Back-to-back: after FIX the counter wraps to LOAD.
  - if go stays high, the next operation loads on the following cycle with the new operands.
- Reset mid-operation: same as an abort, plus outputs clear to 0.
- Simultaneous reset_n low and go high: reset wins.

Test Plan:
- Unsigned basic: sign=0, 100 / 7, go held -> done high only in cycle 34; quotient = 14, remainder = 2.
- Signed negative: sign=1, 0xFFFFFFF9 (-7) / 2 -> quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1).
- Signed negative divisor: sign=1, 7 / 0xFFFFFFFE (-2) -> quotient = 0xFFFFFFFD, remainder = 1.
- Divide by zero:
  - sign=1, 0xFFFFFFFB / 0 -> quotient = 0xFFFFFFFF, remainder = 0xFFFFFFFB.
  - sign=0, 5 / 0 -> quotient = 0xFFFFFFFF, remainder = 5.
- Overflow: sign=1, 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0.
- Control:
  - abort: go dropped at cycle 10, reasserted 3 cycles later with 0xFFFFFFFF / 0x10 unsigned -> done 34 cycles after reassertion; quotient = 0x0FFFFFFF, remainder = 0xF.
  - back-to-back: two operations with go held continuously -> done in cycles 34 and 68.
  - reset_n low at cycle 20 -> no done; outputs = 0.
